// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding word-wide data-memory transaction with lane steering,
// sign/zero extension, misalignment/func3 checking and a response timeout.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2, RESP = 2'd3} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic        r_store, r_have_rsp, r_req_ready, r_mem_req, r_mem_we, r_done, r_wb_we, r_err;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd, r_wb_rd;
  logic [15:0] r_cnt;
  logic [3:0]  r_mem_be;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata, r_wb_data;
  logic        w_timeout, w_req_bad, w_resp_err, w_resp_we, w_accept;
  logic [31:0] w_raw, w_resp_data;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   steer_wdata = {4{wd[7:0]}};
      2'b01:   steer_wdata = {2{wd[15:0]}};
      default: steer_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'h000000, b};
      3'b101:  extend_load = {16'h0000, h};
      default: extend_load = rd;
    endcase
  endfunction

  function automatic logic req_illegal(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic bad_f3, misal;
    bad_f3 = st ? (f3[2] || (f3[1:0] == 2'b11)) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    misal  = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    req_illegal = bad_f3 || misal;
  endfunction

  assign w_req_bad   = req_illegal(req_store, req_func3, req_addr[1:0]);
  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_raw       = r_have_rsp ? r_rdata : mem_rdata;
  assign w_resp_err  = (r_state == IDLE) ? w_req_bad : w_timeout;
  assign w_resp_we   = (r_state == WAIT_RSP) && !w_timeout;
  assign w_resp_data = w_resp_we ? extend_load(r_func3, r_off, w_raw) : 32'h0000_0000;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a load granted together with its data still passes through
  // WAIT_RSP once so every load completes no earlier than three cycles after accept
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_nxt = w_req_bad ? RESP : ISSUE;
        else           w_state_nxt = IDLE;
      end
      ISSUE: begin
        if (mem_gnt) w_state_nxt = r_store ? RESP : WAIT_RSP;
        else         w_state_nxt = ISSUE;
      end
      WAIT_RSP: begin
        if (r_have_rsp || mem_rvalid) begin
          w_state_nxt = RESP;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = RESP;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = WAIT_RSP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, memory-side outputs, timeout counter and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store     <= 1'b0;
      r_func3     <= 3'b000;
      r_off       <= 2'b00;
      r_rd        <= 5'd0;
      r_have_rsp  <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_cnt       <= 16'd0;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_done      <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_mem_req   <= (w_state_nxt == ISSUE);
      if (w_accept) begin
        r_store <= req_store;
        r_func3 <= req_func3;
        r_off   <= req_addr[1:0];
        r_rd    <= req_rd;
        if (!w_req_bad) begin
          r_mem_we    <= req_store;
          r_mem_be    <= lane_be(req_func3, req_addr[1:0]);
          r_mem_addr  <= {req_addr[31:2], 2'b00};
          r_mem_wdata <= req_store ? steer_wdata(req_func3, req_wdata) : 32'h0000_0000;
        end else begin
          r_mem_we <= 1'b0;
        end
      end else if (w_state_nxt != ISSUE) begin
        r_mem_we <= 1'b0;
      end else begin
        r_mem_we <= r_mem_we;
      end
      r_have_rsp <= (r_state == ISSUE) && mem_gnt && mem_rvalid && !r_store;
      if ((r_state == ISSUE) && mem_gnt && mem_rvalid && !r_store) r_rdata <= mem_rdata;
      else                                                         r_rdata <= r_rdata;
      r_cnt <= ((r_state == WAIT_RSP) && (w_state_nxt == WAIT_RSP)) ? r_cnt + 16'd1 : 16'd0;
      if (w_state_nxt == RESP) begin
        r_done    <= 1'b1;
        r_err     <= w_resp_err;
        r_wb_we   <= w_resp_we;
        r_wb_data <= w_resp_data;
        r_wb_rd   <= (r_state == IDLE) ? req_rd : r_rd;
      end else begin
        r_done    <= 1'b0;
        r_err     <= 1'b0;
        r_wb_we   <= 1'b0;
        r_wb_data <= 32'h0000_0000;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign wb_we     = r_wb_we;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed load/store vectors, memory-side checks
// in the stimulus task, completion checks in a decoupled negedge monitor.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        done, wb_we, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic e, input logic we, input logic [4:0] rd, input logic [31:0] d);
    rsp_t r;
    r = {e, we, rd, d};
    sb_q.push_back(r);
  endtask

  // Completion monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 wb_data=0x%08h, required no completion", wb_data);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_err", {31'd0, err}, {31'd0, e.err});
        chk("rsp_wb_we", {31'd0, wb_we}, {31'd0, e.we});
        chk("rsp_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("rsp_wb_data", wb_data, e.data);
      end
    end
  end

  // g: grant in the (g+1)th request cycle; r: rvalid r cycles after grant (0 same cycle, -1 never)
  task automatic run_txn(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int g, input int r, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input int exp_req, input int exp_lat);
    int reqc, gk, dk;
    reqc = 0; gk = 0; dk = 0;
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rdata;
      if (done === 1'b1) begin
        dk = k;
        break;
      end
      chk({nm, "_busy"}, {31'd0, req_ready}, 32'd0);
      if (mem_req === 1'b1) begin
        reqc++;
        chk({nm, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, st});
        if (st) chk({nm, "_wdata"}, mem_wdata, exp_wd);
        if (reqc == g + 1) begin
          mem_gnt = 1'b1;
          gk = k;
          if (r == 0) mem_rvalid = 1'b1;
        end
      end else if (gk > 0 && r > 0 && k == gk + r) begin
        mem_rvalid = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk({nm, "_latency"}, dk, exp_lat);
    chk({nm, "_req_cycles"}, reqc, exp_req);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_func3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_rsp(1'b0, 1'b1, 5'd5, 32'hFFFF_FF80);
    run_txn("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 0, 1, 32'h80FF_1234, 4'b1000, 32'h0, 1, 3);
    expect_rsp(1'b0, 1'b1, 5'd6, 32'h0000_0080);
    run_txn("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd6, 0, 1, 32'h80FF_1234, 4'b1000, 32'h0, 1, 3);
    expect_rsp(1'b0, 1'b0, 5'd7, 32'h0);
    run_txn("sh", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd7, 3, -1, 32'h0, 4'b1100, 32'hABCD_ABCD, 4, 5);
    expect_rsp(1'b1, 1'b0, 5'd8, 32'h0);
    run_txn("lw_misal", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd8, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 1);
    expect_rsp(1'b0, 1'b1, 5'd9, 32'hFFFF_8001);
    run_txn("lh_fast", 1'b0, 3'b001, 32'h0000_0040, 32'h0, 5'd9, 0, 0, 32'h7FFF_8001, 4'b0011, 32'h0, 1, 3);
    expect_rsp(1'b0, 1'b1, 5'd10, 32'h0000_7FFF);
    run_txn("lhu_hi", 1'b0, 3'b101, 32'h0000_0042, 32'h0, 5'd10, 0, 2, 32'h7FFF_8001, 4'b1100, 32'h0, 1, 4);
    expect_rsp(1'b0, 1'b0, 5'd11, 32'h0);
    run_txn("sb", 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd11, 1, -1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 2, 3);
    expect_rsp(1'b1, 1'b0, 5'd12, 32'h0);
    run_txn("lw_timeout", 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd12, 0, -1, 32'h0, 4'b1111, 32'h0, 1, 6);
    expect_rsp(1'b0, 1'b0, 5'd13, 32'h0);
    run_txn("sw", 1'b1, 3'b010, 32'h0000_0084, 32'hDEAD_BEEF, 5'd13, 0, -1, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1, 2);
    expect_rsp(1'b0, 1'b1, 5'd14, 32'h1234_5678);
    run_txn("lw", 1'b0, 3'b010, 32'h0000_0008, 32'h0, 5'd14, 2, 1, 32'h1234_5678, 4'b1111, 32'h0, 3, 5);
    expect_rsp(1'b1, 1'b0, 5'd15, 32'h0);
    run_txn("ld_illegal", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd15, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 1);
    expect_rsp(1'b1, 1'b0, 5'd16, 32'h0);
    run_txn("st_illegal", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 5'd16, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 1);
    expect_rsp(1'b1, 1'b0, 5'd17, 32'h0);
    run_txn("sh_misal", 1'b1, 3'b001, 32'h0000_0001, 32'h0, 5'd17, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 1);

    // Reset while waiting for read data
    req_valid = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_0300; req_rd = 5'd18;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstrel_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_done", {31'd0, done}, 32'd0);
      chk("stray_wb_we", {31'd0, wb_we}, 32'd0);
      chk("stray_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
